// File: rtl/sbox_sched_pkg.sv
// Shared constants and FSM/owner encodings for the time-shared S-box scheduler.
package sbox_sched_pkg;

  localparam int STATE_BYTES = 16;
  localparam int KS_BYTES    = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} st_state_t;
  typedef enum logic [1:0] {KS_IDLE, KS_RUN, KS_ACK} ks_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_ST, OWN_KS} owner_t;

endpackage

// File: rtl/sbox_dual.sv
// Combinational forward/inverse AES S-box pair, selected by inv; zero latency, no flow control.
module sbox_dual (
  input  logic [7:0] addr,
  input  logic       inv,
  output logic [7:0] data
);

  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign data = inv ? INV[addr] : FWD[addr];

endmodule

// File: rtl/sbox_sched.sv
// Shares one S-box pair between a 16-byte state job and a 4-byte SubWord job, one byte per cycle.
// State done in cycle 17, key ack in cycle 5 uncontended; key work can preempt state work per byte.
module sbox_sched
  import sbox_sched_pkg::*;
#(
  parameter int KS_PRIORITY = 1,
  parameter int STATE_BYTES = sbox_sched_pkg::STATE_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_start,
  input  logic         st_inv,
  input  logic [127:0] st_in,
  output logic         st_busy,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         ks_req,
  input  logic [31:0]  ks_in,
  output logic         ks_ack,
  output logic [31:0]  ks_out
);

  st_state_t    st_state, st_next;
  ks_state_t    ks_state, ks_next;
  owner_t       owner;
  logic [127:0] st_buf, st_buf_nx;
  logic [31:0]  ks_buf, ks_buf_nx;
  logic [3:0]   st_cnt;
  logic [1:0]   ks_cnt;
  logic         st_inv_q, st_last, ks_last, sb_inv;
  logic [7:0]   sb_addr, sb_data;

  assign st_last = (st_cnt == 4'(STATE_BYTES - 1));
  assign ks_last = (ks_cnt == 2'(KS_BYTES - 1));
  assign st_busy = (st_state == ST_RUN);
  assign st_done = (st_state == ST_DONE);
  assign ks_ack  = (ks_state == KS_ACK);

  // Without priority the key schedule still gets the S-box as soon as the state job leaves ST_RUN.
  always_comb begin
    owner = OWN_NONE;
    if (ks_state == KS_RUN && (KS_PRIORITY != 0 || st_state != ST_RUN))
      owner = OWN_KS;
    else if (st_state == ST_RUN)
      owner = OWN_ST;
  end

  always_comb begin
    sb_addr = 8'h00;
    sb_inv  = 1'b0;
    case (owner)
      OWN_ST: begin
        sb_addr = st_buf[{st_cnt, 3'b000} +: 8];
        sb_inv  = st_inv_q;
      end
      OWN_KS:  sb_addr = ks_buf[{ks_cnt, 3'b000} +: 8];
      default: ;
    endcase
  end

  sbox_dual u_sbox (
    .addr (sb_addr),
    .inv  (sb_inv),
    .data (sb_data)
  );

  always_comb begin
    st_buf_nx = st_buf;
    ks_buf_nx = ks_buf;
    st_buf_nx[{st_cnt, 3'b000} +: 8] = sb_data;
    ks_buf_nx[{ks_cnt, 3'b000} +: 8] = sb_data;
  end

  always_comb begin
    st_next = st_state;
    ks_next = ks_state;
    case (st_state)
      ST_IDLE: if (st_start) st_next = ST_RUN;
      ST_RUN:  if (owner == OWN_ST && st_last) st_next = ST_DONE;
      default: st_next = ST_IDLE;
    endcase
    case (ks_state)
      KS_IDLE: if (ks_req) ks_next = KS_RUN;
      KS_RUN:  if (owner == OWN_KS && ks_last) ks_next = KS_ACK;
      default: ks_next = KS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_state <= ST_IDLE;
      ks_state <= KS_IDLE;
    end else begin
      st_state <= st_next;
      ks_state <= ks_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_buf   <= '0;
      st_inv_q <= 1'b0;
      st_cnt   <= '0;
      st_out   <= '0;
      ks_buf   <= '0;
      ks_cnt   <= '0;
      ks_out   <= '0;
    end else begin
      if (st_state == ST_IDLE && st_start) begin
        st_buf   <= st_in;
        st_inv_q <= st_inv;
      end else if (owner == OWN_ST) begin
        st_buf <= st_buf_nx;
        st_cnt <= st_last ? 4'd0 : st_cnt + 4'd1;
        if (st_last) st_out <= st_buf_nx;
      end
      if (ks_state == KS_IDLE && ks_req) begin
        ks_buf <= ks_in;
      end else if (owner == OWN_KS) begin
        ks_buf <= ks_buf_nx;
        ks_cnt <= ks_cnt + 2'd1;
        if (ks_last) ks_out <= ks_buf_nx;
      end
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Scoreboard bench for sbox_sched: expected results and completion cycles queued at drive time.
module tb_sbox_sched;

  typedef struct {
    logic [127:0] dat;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         st_start, st_inv, ks_req;
  logic [127:0] st_in;
  logic [31:0]  ks_in;
  logic         st_busy, st_done, ks_ack;
  logic [127:0] st_out;
  logic [31:0]  ks_out;
  logic         p0_st_busy, p0_st_done, p0_ks_ack;
  logic [127:0] p0_st_out;
  logic [31:0]  p0_ks_out;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   p0_done_cyc = 0;
  int   p0_ack_cyc = 0;
  exp_t st_q[$];
  exp_t ks_q[$];
  exp_t st_e, ks_e;
  logic [7:0] fwd_m[256];
  logic [7:0] inv_m[256];

  localparam logic [127:0] D1     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] D1_EXP = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [31:0]  K1     = 32'h53020100;
  localparam logic [31:0]  K1_EXP = 32'hed777c63;

  sbox_sched #(.KS_PRIORITY(1)) u_dut (
    .clk(clk), .rst(rst),
    .st_start(st_start), .st_inv(st_inv), .st_in(st_in),
    .st_busy(st_busy), .st_done(st_done), .st_out(st_out),
    .ks_req(ks_req), .ks_in(ks_in), .ks_ack(ks_ack), .ks_out(ks_out)
  );

  sbox_sched #(.KS_PRIORITY(0)) u_p0 (
    .clk(clk), .rst(rst),
    .st_start(st_start), .st_inv(st_inv), .st_in(st_in),
    .st_busy(p0_st_busy), .st_done(p0_st_done), .st_out(p0_st_out),
    .ks_req(ks_req), .ks_in(ks_in), .ks_ack(p0_ks_ack), .ks_out(p0_ks_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // GF(2^8) reference used to build an independent S-box model.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] q, input int n);
    logic [15:0] t = {q, q} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] st_model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv ? inv_m[d[i*8 +: 8]] : fwd_m[d[i*8 +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] ks_model(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = fwd_m[w[i*8 +: 8]];
    return r;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // One-cycle request pulse; afterwards the inputs are scrambled to prove they are not re-sampled.
  task automatic kick(input bit s, input logic [127:0] d, input bit inv, input bit k, input logic [31:0] w);
    st_start = s;
    st_in    = d;
    st_inv   = inv;
    ks_req   = k;
    ks_in    = w;
    step(1);
    st_start = 1'b0;
    ks_req   = 1'b0;
    st_in    = {$urandom, $urandom, $urandom, $urandom};
    st_inv   = ~inv;
    ks_in    = $urandom;
  endtask

  task automatic push_st(input logic [127:0] d, input int c);
    exp_t e;
    e.dat = d;
    e.cyc = c;
    st_q.push_back(e);
  endtask

  task automatic push_ks(input logic [31:0] d, input int c);
    exp_t e;
    e.dat = {96'h0, d};
    e.cyc = c;
    ks_q.push_back(e);
  endtask

  task automatic drain();
    int k = 0;
    while ((st_q.size() != 0 || ks_q.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk("drain_timeout", 128'(st_q.size() + ks_q.size()), 128'h0);
      st_q.delete();
      ks_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (st_done) begin
        if (st_q.size() == 0) chk("st_done_unexpected", 128'h1, 128'h0);
        else begin
          st_e = st_q.pop_front();
          chk("st_out", st_out, st_e.dat);
          chk("st_done_cycle", 128'(cyc), 128'(st_e.cyc));
        end
      end
      if (ks_ack) begin
        if (ks_q.size() == 0) chk("ks_ack_unexpected", 128'h1, 128'h0);
        else begin
          ks_e = ks_q.pop_front();
          chk("ks_out", {96'h0, ks_out}, ks_e.dat);
          chk("ks_ack_cycle", 128'(cyc), 128'(ks_e.cyc));
        end
      end
      if (p0_st_done) p0_done_cyc = cyc;
      if (p0_ks_ack)  p0_ack_cyc  = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [127:0] r;
    logic [31:0]  w;
    for (int x = 0; x < 256; x++) begin
      fwd_m[x] = sbox_ref(8'(x));
      inv_m[fwd_m[x]] = 8'(x);
    end
    rst = 1'b1; st_start = 1'b0; st_inv = 1'b0; st_in = '0; ks_req = 1'b0; ks_in = '0;
    step(2);
    chk("rst_st_busy", {127'h0, st_busy}, 128'h0);
    chk("rst_st_done", {127'h0, st_done}, 128'h0);
    chk("rst_ks_ack", {127'h0, ks_ack}, 128'h0);
    chk("rst_st_out", st_out, 128'h0);
    chk("rst_ks_out", {96'h0, ks_out}, 128'h0);
    rst = 1'b0;
    step(1);

    // Forward state job with busy window edges.
    n = cyc;
    push_st(D1_EXP, n + 17);
    kick(1, D1, 0, 0, 0);
    wait_cyc(n + 1);  chk("busy_c1", {127'h0, st_busy}, 128'h1);
    wait_cyc(n + 16); chk("busy_c16", {127'h0, st_busy}, 128'h1);
    wait_cyc(n + 17); chk("busy_c17", {127'h0, st_busy}, 128'h0);
    drain();
    step(3);
    chk("st_out_hold", st_out, D1_EXP);

    // Inverse state jobs.
    n = cyc;
    push_st(128'h0, n + 17);
    kick(1, {16{8'h63}}, 1, 0, 0);
    drain(); step(1);
    n = cyc;
    push_st(128'h53ff, n + 17);
    kick(1, {{14{8'h63}}, 8'hed, 8'h16}, 1, 0, 0);
    drain(); step(1);

    // Key schedule alone, single-cycle ack.
    n = cyc;
    push_ks(K1_EXP, n + 5);
    kick(0, '0, 0, 1, K1);
    wait_cyc(n + 6);
    chk("ks_ack_pulse", {127'h0, ks_ack}, 128'h0);
    drain(); step(1);

    // Key request lands while the state job is on byte 6.
    n = cyc;
    push_st(D1_EXP, n + 21);
    kick(1, D1, 0, 0, 0);
    step(5);
    push_ks(K1_EXP, n + 11);
    kick(0, '0, 0, 1, K1);
    drain(); step(2);
    chk("p0_done_cycle", 128'(p0_done_cyc), 128'(n + 17));
    chk("p0_ack_after_done", {127'h0, p0_ack_cyc > p0_done_cyc}, 128'h1);
    chk("p0_st_out", p0_st_out, D1_EXP);
    chk("p0_ks_out", {96'h0, p0_ks_out}, {96'h0, K1_EXP});
    step(1);

    // st_start while busy is ignored.
    r = {$urandom, $urandom, $urandom, $urandom};
    n = cyc;
    push_st(st_model(r, 0), n + 17);
    kick(1, r, 0, 0, 0);
    step(4);
    kick(1, ~r, 1, 0, 0);
    drain(); step(1);

    // Simultaneous requests from idle: key schedule first.
    r = {$urandom, $urandom, $urandom, $urandom};
    w = $urandom;
    n = cyc;
    push_ks(ks_model(w), n + 5);
    push_st(st_model(r, 1), n + 21);
    kick(1, r, 1, 1, w);
    drain(); step(2);

    // Reset during byte 9 abandons the job.
    r = {$urandom, $urandom, $urandom, $urandom};
    n = cyc;
    push_st(st_model(r, 0), n + 17);
    kick(1, r, 0, 0, 0);
    step(9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_st_busy", {127'h0, st_busy}, 128'h0);
    chk("mid_rst_st_done", {127'h0, st_done}, 128'h0);
    chk("mid_rst_st_out", st_out, 128'h0);
    chk("mid_rst_ks_out", {96'h0, ks_out}, 128'h0);
    st_q.delete();
    step(2);
    rst = 1'b0;
    step(20);
    n = cyc;
    push_st(st_model(r, 0), n + 17);
    kick(1, r, 0, 0, 0);
    drain(); step(1);

    // Random table coverage.
    for (int i = 0; i < 6; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      w = $urandom;
      n = cyc;
      if (i % 3 == 2) begin
        push_ks(ks_model(w), n + 5);
        kick(0, '0, 0, 1, w);
      end else begin
        push_st(st_model(r, i[0]), n + 17);
        kick(1, r, i[0], 0, 0);
      end
      drain(); step(1);
    end

    step(5);
    chk("st_q_empty", 128'(st_q.size()), 128'h0);
    chk("ks_q_empty", 128'(ks_q.size()), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
